// File: rtl/aurora_rx_pkg.sv
// Shared types and constants for the Aurora RX store-and-forward frame buffer.
package aurora_rx_pkg;

   localparam int DEF_DATA_W = 128;

   typedef struct packed {
      logic [DEF_DATA_W-1:0]   tdata;
      logic [DEF_DATA_W/8-1:0] tkeep;
      logic                    tlast;
   } rx_beat_t;

   typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_e;

   // Stored beat width for an arbitrary data width; equals $bits(rx_beat_t) at DEF_DATA_W.
   function automatic int beat_bits(input int data_w);
      return data_w + data_w / 8 + 1;
   endfunction

endpackage

// File: rtl/aurora_rx_frame_buffer_sdp_ram.sv
// Simple dual-port RAM, one clock, registered read with 1-cycle latency.
module sdp_ram_1clk #(
   parameter int WIDTH  = 145,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/aurora_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: commits only complete in-limit frames from a
// no-backpressure Aurora user interface and replays them on an AXI-Stream master.
module aurora_rx_frame_buffer
   import aurora_rx_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = 512,
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = 16
) (
   input  logic                user_clk,
   input  logic                system_rst,
   input  logic                channel_up,
   input  logic [DATA_W-1:0]   s_rx_tdata,
   input  logic [DATA_W/8-1:0] s_rx_tkeep,
   input  logic                s_rx_tlast,
   input  logic                s_rx_tvalid,
   output logic [DATA_W-1:0]   m_tdata,
   output logic [DATA_W/8-1:0] m_tkeep,
   output logic                m_tlast,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic [CNT_W-1:0]    frame_ok_cnt,
   output logic [CNT_W-1:0]    frame_drop_cnt,
   output logic                overflow_pulse
);

   localparam int BEAT_W = beat_bits(DATA_W);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int BCNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);
   localparam logic [BCNT_W-1:0] MAX_B   = BCNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   wr_state_e         state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
   logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d, drop_cnt_q, drop_cnt_d;
   logic              ovf_q, ovf_d, rd_pend_q, rd_pend_d;
   logic [1:0]        sk_cnt_q, sk_cnt_d;
   logic [BEAT_W-1:0] sk0_q, sk0_d, sk1_q, sk1_d;
   logic [BEAT_W-1:0] ram_rdata;
   logic              ram_we, ram_re, full, too_long, pop;
   logic [2:0]        occ;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      beat_cnt_d  = beat_cnt_q;
      ok_cnt_d    = ok_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      ovf_d       = 1'b0;
      ram_we      = 1'b0;
      full        = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
      too_long    = (state_q == WRITE) && (beat_cnt_q == MAX_B);
      if (!channel_up) begin
         if (state_q == WRITE) begin
            wr_ptr_d   = wr_commit_q;
            drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + CNT_ONE;
         end
         state_d = IDLE;
      end else if (s_rx_tvalid) begin
         if (state_q == DROP) begin
            if (s_rx_tlast) state_d = IDLE;
         end else if (full || too_long) begin
            wr_ptr_d   = wr_commit_q;
            drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + CNT_ONE;
            ovf_d      = full;
            state_d    = s_rx_tlast ? IDLE : DROP;
         end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_rx_tlast) begin
               wr_commit_d = wr_ptr_q + PTR_ONE;
               ok_cnt_d    = (ok_cnt_q == '1) ? ok_cnt_q : ok_cnt_q + CNT_ONE;
               beat_cnt_d  = '0;
               state_d     = IDLE;
            end else begin
               beat_cnt_d = (state_q == IDLE) ? BCNT_W'(1) : beat_cnt_q + BCNT_W'(1);
               state_d    = WRITE;
            end
         end
      end
   end

   // fetch_ptr feeds the RAM/skid path; rd_ptr only retires on consumer pop, so
   // beats parked in the skid register still count towards full.
   always_comb begin
      pop         = (sk_cnt_q != 2'd0) && m_tready;
      occ         = {1'b0, sk_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
      ram_re      = (fetch_ptr_q != wr_commit_q) && (occ <= 3'd1);
      fetch_ptr_d = ram_re ? fetch_ptr_q + PTR_ONE : fetch_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      rd_pend_d   = ram_re;
      sk0_d       = sk0_q;
      sk1_d       = sk1_q;
      sk_cnt_d    = sk_cnt_q;
      case ({rd_pend_q, pop})
         2'b10: begin
            if (sk_cnt_q == 2'd0) sk0_d = ram_rdata;
            else sk1_d = ram_rdata;
            sk_cnt_d = sk_cnt_q + 2'd1;
         end
         2'b01: begin
            sk0_d    = sk1_q;
            sk_cnt_d = sk_cnt_q - 2'd1;
         end
         2'b11: begin
            if (sk_cnt_q == 2'd1) sk0_d = ram_rdata;
            else begin
               sk0_d = sk1_q;
               sk1_d = ram_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge user_clk or posedge system_rst) begin
      if (system_rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
         fetch_ptr_q <= '0;
         beat_cnt_q  <= '0;
         ok_cnt_q    <= '0;
         drop_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         rd_pend_q   <= 1'b0;
         sk_cnt_q    <= '0;
         sk0_q       <= '0;
         sk1_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
         fetch_ptr_q <= fetch_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         ok_cnt_q    <= ok_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         ovf_q       <= ovf_d;
         rd_pend_q   <= rd_pend_d;
         sk_cnt_q    <= sk_cnt_d;
         sk0_q       <= sk0_d;
         sk1_q       <= sk1_d;
      end
   end

   sdp_ram_1clk #(
      .WIDTH (BEAT_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (user_clk),
      .we    (ram_we),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata ({s_rx_tdata, s_rx_tkeep, s_rx_tlast}),
      .re    (ram_re),
      .raddr (fetch_ptr_q[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   assign {m_tdata, m_tkeep, m_tlast} = sk0_q;
   assign m_tvalid       = (sk_cnt_q != 2'd0);
   assign frame_ok_cnt   = ok_cnt_q;
   assign frame_drop_cnt = drop_cnt_q;
   assign overflow_pulse = ovf_q;

endmodule

// File: tb/tb_aurora_rx_frame_buffer.sv
// Directed bench: dut_a is a 16-deep buffer for overflow cases, dut_b limits frames to 8 beats.
module tb_aurora_rx_frame_buffer;

   localparam int DW = 32;
   localparam int KW = DW / 8;
   localparam int BW = DW + KW + 1;

   logic clk = 1'b0, rst = 1'b1, chup = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic s_tlast = 1'b0, s_tvalid = 1'b0;

   logic [DW-1:0] a_tdata, b_tdata;
   logic [KW-1:0] a_tkeep, b_tkeep;
   logic a_tlast, a_tvalid, a_tready = 1'b1, a_ovf;
   logic b_tlast, b_tvalid, b_tready = 1'b1, b_ovf;
   logic [15:0] a_ok, a_drop, b_ok, b_drop;

   int checks = 0, failures = 0, cyc = 0;
   int a_ovf_n = 0, a_first_v = -1;
   logic [BW-1:0] qa[$], qb[$];
   logic b_stall = 1'b0;
   logic [BW:0] b_prev;
   logic rnd_on = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   aurora_rx_frame_buffer #(.DATA_W(DW), .DEPTH(16), .MAX_BEATS(256), .CNT_W(16)) dut_a (
      .user_clk(clk), .system_rst(rst), .channel_up(chup),
      .s_rx_tdata(s_tdata), .s_rx_tkeep(s_tkeep), .s_rx_tlast(s_tlast), .s_rx_tvalid(s_tvalid),
      .m_tdata(a_tdata), .m_tkeep(a_tkeep), .m_tlast(a_tlast), .m_tvalid(a_tvalid),
      .m_tready(a_tready), .frame_ok_cnt(a_ok), .frame_drop_cnt(a_drop), .overflow_pulse(a_ovf));

   aurora_rx_frame_buffer #(.DATA_W(DW), .DEPTH(512), .MAX_BEATS(8), .CNT_W(16)) dut_b (
      .user_clk(clk), .system_rst(rst), .channel_up(chup),
      .s_rx_tdata(s_tdata), .s_rx_tkeep(s_tkeep), .s_rx_tlast(s_tlast), .s_rx_tvalid(s_tvalid),
      .m_tdata(b_tdata), .m_tkeep(b_tkeep), .m_tlast(b_tlast), .m_tvalid(b_tvalid),
      .m_tready(b_tready), .frame_ok_cnt(b_ok), .frame_drop_cnt(b_drop), .overflow_pulse(b_ovf));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected beat {tdata, tkeep, tlast}: data tags frame id and beat index, last beat has partial keep.
   function automatic logic [BW-1:0] mk(input int id, input int i, input int n);
      logic [KW-1:0] k;
      k = (i == n - 1) ? 4'b0111 : 4'hF;
      return {16'(id), 16'(i), k, (i == n - 1)};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         b_stall = 1'b0;
      end else begin
         if (a_tvalid && a_tready) qa.push_back({a_tdata, a_tkeep, a_tlast});
         if (b_tvalid && b_tready) qb.push_back({b_tdata, b_tkeep, b_tlast});
         if (a_ovf) a_ovf_n++;
         if (a_tvalid && a_first_v < 0) a_first_v = cyc;
         if (b_stall) check("b_stable", {b_tvalid, b_tdata, b_tkeep, b_tlast}, b_prev);
         b_stall = b_tvalid && !b_tready;
         b_prev  = {b_tvalid, b_tdata, b_tkeep, b_tlast};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [BW-1:0] b);
      {s_tdata, s_tkeep, s_tlast} = b;
      s_tvalid = 1'b1;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int id, input int n);
      for (int i = 0; i < n; i++) send_beat(mk(id, i, n));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_tvalid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      qa.delete();
      qb.delete();
      a_ovf_n = 0;
      a_first_v = -1;
      tick();
   endtask

   task automatic wait_q(input int sel, input int n, input string tag);
      for (int k = 0; k < 400 && ((sel == 0) ? qa.size() : qb.size()) < n; k++) tick();
      repeat (6) tick();
      check(tag, (sel == 0) ? qa.size() : qb.size(), n);
   endtask

   task automatic check_q(input int sel, input int id, input int n, input string tag);
      for (int i = 0; i < n; i++)
         check(tag, (sel == 0) ? qa[i] : qb[i], mk(id, i, n));
   endtask

   initial begin
      int ce;
      do_reset();
      check("rst_a_tvalid", a_tvalid, 1'b0);
      check("rst_a_beat", {a_tdata, a_tkeep, a_tlast}, '0);
      check("rst_a_cnts", {a_ok, a_drop, a_ovf}, '0);
      check("rst_b_tvalid", b_tvalid, 1'b0);

      // 1: 4-beat frame with ready high
      send_frame(1, 4);
      ce = cyc;
      wait_q(0, 4, "t1_count");
      check_q(0, 1, 4, "t1_beat");
      check("t1_latency_ge2", (a_first_v - ce) >= 2, 1'b1);
      check("t1_ok", a_ok, 16'd1);
      check("t1_drop", a_drop, 16'd0);

      // 2: overflow on 16-deep buffer with consumer stalled
      do_reset();
      a_tready = 1'b0;
      send_frame(2, 10);
      send_frame(3, 10);
      repeat (5) tick();
      check("t2_drop", a_drop, 16'd1);
      check("t2_ok", a_ok, 16'd1);
      check("t2_ovf_pulses", a_ovf_n, 1);
      check("t2_no_out_stalled", qa.size(), 0);
      a_tready = 1'b1;
      wait_q(0, 10, "t2_count");
      check_q(0, 2, 10, "t2_beat");

      // 3: frame longer than MAX_BEATS on dut_b
      do_reset();
      send_frame(4, 9);
      send_frame(5, 2);
      wait_q(1, 2, "t3_count");
      check_q(1, 5, 2, "t3_beat");
      check("t3_drop", b_drop, 16'd1);
      check("t3_ok", b_ok, 16'd1);

      // 4: channel loss after beat 3 of a 5-beat frame
      do_reset();
      for (int i = 0; i < 3; i++) send_beat(mk(6, i, 5));
      chup = 1'b0;
      for (int i = 3; i < 5; i++) send_beat(mk(6, i, 5));
      repeat (3) tick();
      chup = 1'b1;
      repeat (8) tick();
      check("t4_no_out", qa.size(), 0);
      check("t4_drop", a_drop, 16'd1);
      check("t4_ok", a_ok, 16'd0);
      check("t4_wr_ptr", dut_a.wr_ptr_q, 0);
      check("t4_wr_commit", dut_a.wr_commit_q, 0);
      send_frame(7, 2);
      wait_q(0, 2, "t4_next_count");
      check_q(0, 7, 2, "t4_next_beat");

      // 5: 100 single-beat frames, random ready on dut_b
      do_reset();
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk);
            #1;
            if (rnd_on) b_tready = ($urandom_range(0, 3) != 0);
         end
      join_none
      for (int i = 0; i < 100; i++) send_frame(1000 + i, 1);
      for (int k = 0; k < 600 && qb.size() < 100; k++) tick();
      rnd_on = 1'b0;
      b_tready = 1'b1;
      wait_q(1, 100, "t5_count");
      for (int i = 0; i < 100; i++) check("t5_beat", qb[i], mk(1000 + i, 0, 1));
      check("t5_ok", b_ok, 16'd100);
      check("t5_drop", b_drop, 16'd0);

      // 6: reset mid-frame and mid-output, then a clean frame
      do_reset();
      a_tready = 1'b0;
      send_frame(200, 3);
      for (int i = 0; i < 2; i++) send_beat(mk(201, i, 5));
      a_tready = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      check("t6_rst_tvalid", a_tvalid, 1'b0);
      check("t6_rst_beat", {a_tdata, a_tkeep, a_tlast}, '0);
      check("t6_rst_cnts", {a_ok, a_drop, a_ovf}, '0);
      rst = 1'b0;
      qa.delete();
      qb.delete();
      tick();
      send_frame(202, 3);
      wait_q(0, 3, "t6_count");
      check_q(0, 202, 3, "t6_beat");
      check("t6_ok", a_ok, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
